// File: rtl/addr_mode_sequencer.sv
// rtl/addr_mode_sequencer.sv - fetch/decode sequencer for MOV, MVI and LDA addressing modes
// Owns the PC and issues one register-file write per completed data instruction.
module addr_mode_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [2:0]  ACC_REG  = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  rf_rd_addr,
  input  logic [15:0] rf_rd_data,
  output logic        rf_we,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic [15:0] pc,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_HALTED, S_FETCH, S_DECODE, S_IMM, S_ADDR, S_LOAD, S_WRITE
  } state_t;

  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_MVI = 4'b1100;
  localparam logic [3:0] OP_LDA = 4'b1101;

  state_t      state;
  logic [15:6] ir;
  logic [15:0] ea;
  logic [15:0] data;

  // Request and address decode straight from the state register so reset drops them at once.
  assign mem_req    = (state == S_FETCH) || (state == S_IMM) ||
                      (state == S_ADDR)  || (state == S_LOAD);
  assign mem_addr   = (state == S_LOAD) ? ea : pc;
  assign busy       = (state != S_HALTED);
  assign rf_rd_addr = ir[8:6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_HALTED;
      pc         <= RESET_PC;
      ir         <= '0;
      ea         <= '0;
      data       <= '0;
      rf_we      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      illegal    <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_HALTED: begin
          if (!halt) state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata[15:6];
            pc    <= pc + 16'd1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (ir[15:12])
            OP_MOV: begin
              data  <= rf_rd_data;
              state <= S_WRITE;
            end
            OP_MVI:  state <= S_IMM;
            OP_LDA:  state <= S_ADDR;
            default: begin
              illegal <= 1'b1;
              state   <= halt ? S_HALTED : S_FETCH;
            end
          endcase
        end
        S_IMM: begin
          if (mem_ack) begin
            data  <= mem_rdata;
            pc    <= pc + 16'd1;
            state <= S_WRITE;
          end
        end
        S_ADDR: begin
          if (mem_ack) begin
            ea    <= mem_rdata;
            pc    <= pc + 16'd1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (mem_ack) begin
            data  <= mem_rdata;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          rf_we      <= 1'b1;
          rf_wr_addr <= (ir[15:12] == OP_LDA) ? ACC_REG : ir[11:9];
          rf_wr_data <= data;
          state      <= halt ? S_HALTED : S_FETCH;
        end
        default: state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// tb/tb_addr_mode_sequencer.sv - self-checking bench for addr_mode_sequencer
module tb_addr_mode_sequencer;

  localparam logic [2:0] ACC0 = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        sel = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;

  logic        req0, req1, we0, we1, ill0, ill1, busy0, busy1;
  logic [15:0] addr0, addr1, wd0, wd1, pc0, pc1, rd0, rd1;
  logic [2:0]  ra0, ra1, wa0, wa1;
  logic        rst0, rst1, ack0, ack1;

  logic        m_req, m_we, m_ill, m_busy;
  logic [15:0] m_addr, m_wd, m_pc;
  logic [2:0]  m_wa;

  logic [15:0] mem [0:65535];
  logic [15:0] regs [8];

  int cyc = 0, base = 0, checks = 0, errors = 0, events = 0, ev_target = 0;
  logic [15:0] pc_snap = 16'h0000;

  int          wait_q[$];
  int          wcnt = 0;
  logic        req_active = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic        addr_unstable = 1'b0;

  logic [15:0] req_log[$];
  int          ev_kind[$], ev_cyc[$];
  logic [2:0]  ev_addr[$];
  logic [15:0] ev_data[$];

  logic [15:0] exp_req[$];
  int          exp_kind[$], exp_cyc[$];
  logic [2:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  logic [15:0] exp_pc;

  // Two instances share one memory/register model; the idle one is held in reset.
  assign rst0 = rst | sel;
  assign rst1 = rst | ~sel;
  assign ack0 = mem_ack & ~sel;
  assign ack1 = mem_ack & sel;
  assign rd0  = regs[ra0];
  assign rd1  = regs[ra1];
  assign m_req  = sel ? req1  : req0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_we   = sel ? we1   : we0;
  assign m_wa   = sel ? wa1   : wa0;
  assign m_wd   = sel ? wd1   : wd0;
  assign m_pc   = sel ? pc1   : pc0;
  assign m_ill  = sel ? ill1  : ill0;
  assign m_busy = sel ? busy1 : busy0;

  addr_mode_sequencer #(.RESET_PC(16'h0000), .ACC_REG(ACC0)) dut0 (
    .clk(clk), .rst(rst0), .halt(halt),
    .mem_req(req0), .mem_addr(addr0), .mem_ack(ack0), .mem_rdata(mem_rdata),
    .rf_rd_addr(ra0), .rf_rd_data(rd0),
    .rf_we(we0), .rf_wr_addr(wa0), .rf_wr_data(wd0),
    .pc(pc0), .busy(busy0), .illegal(ill0)
  );

  addr_mode_sequencer #(.RESET_PC(16'hFFFF), .ACC_REG(3'd0)) dut1 (
    .clk(clk), .rst(rst1), .halt(halt),
    .mem_req(req1), .mem_addr(addr1), .mem_ack(ack1), .mem_rdata(mem_rdata),
    .rf_rd_addr(ra1), .rf_rd_data(rd1),
    .rf_we(we1), .rf_wr_addr(wa1), .rf_wr_data(wd1),
    .pc(pc1), .busy(busy1), .illegal(ill1)
  );

  always @(posedge clk) cyc++;

  // Memory responder: per-request wait counts come from wait_q.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      req_active = 1'b0;
    end else if (m_req) begin
      if (!req_active) begin
        req_active = 1'b1;
        req_addr = m_addr;
        if (wait_q.size() > 0) wcnt = wait_q.pop_front();
        else wcnt = 0;
      end else if (m_addr !== req_addr) begin
        addr_unstable = 1'b1;
      end
      if (wcnt == 0) begin
        mem_ack = 1'b1;
        mem_rdata = mem[m_addr];
        req_log.push_back(m_addr);
        req_active = 1'b0;
      end else begin
        mem_ack = 1'b0;
        wcnt--;
      end
    end else begin
      mem_ack = 1'b0;
      req_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_we) begin
        ev_kind.push_back(0); ev_addr.push_back(m_wa); ev_data.push_back(m_wd);
        ev_cyc.push_back(cyc - base);
        regs[m_wa] = m_wd;
        events++;
        if (events == ev_target) pc_snap = m_pc;
      end
      if (m_ill) begin
        ev_kind.push_back(1); ev_addr.push_back(3'd0); ev_data.push_back(16'h0000);
        ev_cyc.push_back(cyc - base);
        events++;
        if (events == ev_target) pc_snap = m_pc;
      end
    end
  end

  task automatic do_reset(input bit s);
    @(negedge clk);
    rst = 1'b1; halt = 1'b0; sel = s;
    wait_q.delete(); req_log.delete();
    ev_kind.delete(); ev_addr.delete(); ev_data.delete(); ev_cyc.delete();
    events = 0; addr_unstable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst(input int n);
    ev_target = n;
    base = cyc;
    rst = 1'b0;
  endtask

  task automatic wait_events(input int n, output bit ok);
    int b;
    b = 0;
    while (events < n && b < 4000) begin
      @(negedge clk);
      b++;
    end
    ok = (events >= n);
  endtask

  // Instruction-level reference: walks the program word by word, accumulating cycle cost.
  task automatic model_run(input int n, input logic [15:0] start, input logic [2:0] acc);
    logic [15:0] r [8];
    logic [15:0] p, w, a, d;
    logic [2:0]  wa;
    int wq[$];
    int t, len, nreq, kind;
    r = regs; wq = wait_q; p = start; t = 1;
    exp_req.delete(); exp_kind.delete(); exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    for (int i = 0; i < n; i++) begin
      w = mem[p]; exp_req.push_back(p); p = p + 16'd1;
      kind = 0; d = 16'h0000; wa = 3'd0;
      if (w[15:12] == 4'hC) begin
        d = mem[p]; exp_req.push_back(p); p = p + 16'd1;
        wa = w[11:9]; len = 4; nreq = 2;
      end else if (w[15:12] == 4'hD) begin
        a = mem[p]; exp_req.push_back(p); p = p + 16'd1;
        exp_req.push_back(a); d = mem[a];
        wa = acc; len = 5; nreq = 3;
      end else if (w[15:12] == 4'hB) begin
        d = r[w[8:6]]; wa = w[11:9]; len = 3; nreq = 1;
      end else begin
        kind = 1; len = 2; nreq = 1;
      end
      for (int k = 0; k < nreq; k++) if (wq.size() > 0) t += wq.pop_front();
      t += len;
      exp_kind.push_back(kind); exp_addr.push_back(wa); exp_data.push_back(d); exp_cyc.push_back(t);
      if (kind == 0) r[wa] = d;
    end
    exp_pc = p;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", m_req); end
    checks++; if (m_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", m_addr); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", m_we); end
    checks++; if (m_wa !== 3'd0) begin errors++; $display("FAIL reset_rf_wr_addr got=%0d exp=0", m_wa); end
    checks++; if (m_wd !== 16'h0000) begin errors++; $display("FAIL reset_rf_wr_data got=%h exp=0000", m_wd); end
    checks++; if (m_ill !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", m_ill); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", m_busy); end
    checks++; if (m_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", m_pc); end
    checks++; if (pc1 !== 16'hFFFF || addr1 !== 16'hFFFF) begin
      errors++; $display("FAIL reset_pc_param got=%h/%h exp=ffff/ffff", pc1, addr1);
    end
  endtask

  task automatic test_mov;
    bit ok;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[2] = 16'h1234; mem[0] = 16'hB680; mem[1] = 16'h0000;
    release_rst(1); wait_events(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mov_timeout events=%0d exp=1", events); end
    if (ok) begin
      checks++; if (ev_kind[0] !== 0) begin errors++; $display("FAIL mov_kind got=%0d exp=0", ev_kind[0]); end
      checks++; if (ev_addr[0] !== 3'd3 || ev_data[0] !== 16'h1234) begin
        errors++; $display("FAIL mov_write got=%0d/%h exp=3/1234", ev_addr[0], ev_data[0]);
      end
      checks++; if (ev_cyc[0] !== 4) begin errors++; $display("FAIL mov_latency got=%0d exp=4", ev_cyc[0]); end
      checks++; if (pc_snap !== 16'h0001) begin errors++; $display("FAIL mov_pc got=%h exp=0001", pc_snap); end
    end
  endtask

  task automatic test_mvi_waits;
    bit ok;
    do_reset(1'b0);
    mem[0] = 16'hCA00; mem[1] = 16'hBEEF; mem[2] = 16'h0000;
    for (int i = 0; i < 4; i++) wait_q.push_back(2);
    release_rst(1); wait_events(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mvi_timeout events=%0d exp=1", events); end
    if (ok) begin
      checks++; if (ev_addr[0] !== 3'd5 || ev_data[0] !== 16'hBEEF) begin
        errors++; $display("FAIL mvi_write got=%0d/%h exp=5/beef", ev_addr[0], ev_data[0]);
      end
      checks++; if (ev_cyc[0] !== 9) begin errors++; $display("FAIL mvi_latency got=%0d exp=9", ev_cyc[0]); end
      checks++; if (pc_snap !== 16'h0002) begin errors++; $display("FAIL mvi_pc got=%h exp=0002", pc_snap); end
      checks++; if (req_log[0] !== 16'h0000 || req_log[1] !== 16'h0001) begin
        errors++; $display("FAIL mvi_reqs got=%h,%h exp=0000,0001", req_log[0], req_log[1]);
      end
    end
    checks++; if (addr_unstable !== 1'b0) begin errors++; $display("FAIL mvi_addr_stable got=%b exp=0", addr_unstable); end
  endtask

  task automatic test_lda;
    bit ok;
    do_reset(1'b0);
    mem[0] = 16'hD000; mem[1] = 16'h0040; mem[2] = 16'h0000; mem[16'h0040] = 16'h5A5A;
    release_rst(1); wait_events(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lda_timeout events=%0d exp=1", events); end
    if (ok) begin
      checks++; if (req_log[0] !== 16'h0000 || req_log[1] !== 16'h0001 || req_log[2] !== 16'h0040) begin
        errors++; $display("FAIL lda_reqs got=%h,%h,%h exp=0000,0001,0040", req_log[0], req_log[1], req_log[2]);
      end
      checks++; if (ev_addr[0] !== ACC0 || ev_data[0] !== 16'h5A5A) begin
        errors++; $display("FAIL lda_write got=%0d/%h exp=%0d/5a5a", ev_addr[0], ev_data[0], ACC0);
      end
      checks++; if (ev_cyc[0] !== 6) begin errors++; $display("FAIL lda_latency got=%0d exp=6", ev_cyc[0]); end
      checks++; if (pc_snap !== 16'h0002) begin errors++; $display("FAIL lda_pc got=%h exp=0002", pc_snap); end
    end
  endtask

  task automatic test_illegal;
    bit ok;
    do_reset(1'b0);
    regs[2] = 16'h7777; mem[0] = 16'h0000; mem[1] = 16'hB680; mem[2] = 16'h0000;
    release_rst(2); wait_events(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL illegal_timeout events=%0d exp=2", events); end
    if (ok) begin
      checks++; if (ev_kind[0] !== 1 || ev_cyc[0] !== 3) begin
        errors++; $display("FAIL illegal_pulse got=kind%0d@%0d exp=kind1@3", ev_kind[0], ev_cyc[0]);
      end
      checks++; if (ev_kind[1] !== 0 || ev_cyc[1] !== 6 || ev_data[1] !== 16'h7777) begin
        errors++; $display("FAIL illegal_next got=kind%0d@%0d/%h exp=kind0@6/7777", ev_kind[1], ev_cyc[1], ev_data[1]);
      end
      checks++; if (req_log[1] !== 16'h0001) begin errors++; $display("FAIL illegal_next_fetch got=%h exp=0001", req_log[1]); end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset(1'b1);
    mem[16'hFFFF] = 16'hC200; mem[0] = 16'hABCD; mem[1] = 16'h0000;
    release_rst(1); wait_events(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout events=%0d exp=1", events); end
    if (ok) begin
      checks++; if (req_log[0] !== 16'hFFFF || req_log[1] !== 16'h0000) begin
        errors++; $display("FAIL wrap_reqs got=%h,%h exp=ffff,0000", req_log[0], req_log[1]);
      end
      checks++; if (ev_addr[0] !== 3'd1 || ev_data[0] !== 16'hABCD || ev_cyc[0] !== 5) begin
        errors++; $display("FAIL wrap_write got=%0d/%h@%0d exp=1/abcd@5", ev_addr[0], ev_data[0], ev_cyc[0]);
      end
      checks++; if (pc_snap !== 16'h0001) begin errors++; $display("FAIL wrap_pc got=%h exp=0001", pc_snap); end
    end
  endtask

  task automatic test_reset_in_load;
    int b;
    do_reset(1'b0);
    mem[0] = 16'hD000; mem[1] = 16'h0040; mem[16'h0040] = 16'h5A5A;
    wait_q.push_back(0); wait_q.push_back(0); wait_q.push_back(20);
    release_rst(1);
    b = 0;
    while (!(m_req === 1'b1 && m_addr === 16'h0040) && b < 100) begin @(negedge clk); b++; end
    checks++; if (b >= 100) begin errors++; $display("FAIL rstload_reach got=timeout exp=load_request"); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rstload_req_drop got=%b exp=0", m_req); end
    checks++; if (m_pc !== 16'h0000 || m_busy !== 1'b0) begin
      errors++; $display("FAIL rstload_state got=pc%h/busy%b exp=pc0000/busy0", m_pc, m_busy);
    end
    repeat (3) @(negedge clk);
    checks++; if (events !== 0) begin errors++; $display("FAIL rstload_no_write got=%0d exp=0", events); end
  endtask

  task automatic test_halt_imm;
    int b;
    bit ok;
    do_reset(1'b0);
    mem[0] = 16'hCA00; mem[1] = 16'h1234; mem[2] = 16'h0000;
    wait_q.push_back(0); wait_q.push_back(3);
    release_rst(1);
    b = 0;
    while (!(m_req === 1'b1 && m_addr === 16'h0001) && b < 100) begin @(negedge clk); b++; end
    halt = 1'b1;
    wait_events(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_timeout events=%0d exp=1", events); end
    if (ok) begin
      checks++; if (ev_addr[0] !== 3'd5 || ev_data[0] !== 16'h1234) begin
        errors++; $display("FAIL halt_write got=%0d/%h exp=5/1234", ev_addr[0], ev_data[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (m_busy !== 1'b0 || m_req !== 1'b0) begin
        errors++; $display("FAIL halt_parked got=busy%b/req%b exp=busy0/req0", m_busy, m_req);
      end
    end
    halt = 1'b0;
    @(negedge clk);
    checks++; if (m_req !== 1'b1 || m_addr !== 16'h0002 || m_busy !== 1'b1) begin
      errors++; $display("FAIL halt_resume got=req%b/%h exp=req1/0002", m_req, m_addr);
    end
  endtask

  task automatic test_random;
    bit ok, s;
    int kind;
    logic [15:0] p, start;
    logic [3:0]  op;
    logic [2:0]  acc;
    for (int r = 0; r < 6; r++) begin
      s = (r % 2) == 1;
      do_reset(s);
      start = s ? 16'hFFFF : 16'h0000;
      acc = s ? 3'd0 : ACC0;
      p = start;
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: op = 4'hB;
          1: op = 4'hC;
          2: op = 4'hD;
          default: begin
            do op = 4'($urandom_range(0, 15)); while (op == 4'hB || op == 4'hC || op == 4'hD);
          end
        endcase
        mem[p] = {op, 3'($urandom), 3'($urandom), 6'($urandom)};
        p = p + 16'd1;
        if (kind == 1) begin mem[p] = 16'($urandom); p = p + 16'd1; end
        if (kind == 2) begin mem[p] = 16'h0100 + 16'($urandom_range(0, 15)); p = p + 16'd1; end
      end
      mem[p] = 16'h0000;
      for (int i = 0; i < 64; i++) wait_q.push_back($urandom_range(0, 2));
      model_run(16, start, acc);
      release_rst(16); wait_events(16, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout events=%0d exp=16", r, events); end
      if (ok) begin
        for (int i = 0; i < 16; i++) begin
          checks++; if (ev_kind[i] !== exp_kind[i] || ev_cyc[i] !== exp_cyc[i]) begin
            errors++; $display("FAIL rand%0d_event%0d got=kind%0d@%0d exp=kind%0d@%0d", r, i, ev_kind[i], ev_cyc[i], exp_kind[i], exp_cyc[i]);
          end
          if (exp_kind[i] == 0) begin
            checks++; if (ev_addr[i] !== exp_addr[i] || ev_data[i] !== exp_data[i]) begin
              errors++; $display("FAIL rand%0d_write%0d got=%0d/%h exp=%0d/%h", r, i, ev_addr[i], ev_data[i], exp_addr[i], exp_data[i]);
            end
          end
        end
        checks++;
        if (req_log.size() < exp_req.size()) begin
          errors++; $display("FAIL rand%0d_req_count got=%0d exp=%0d", r, req_log.size(), exp_req.size());
        end else begin
          for (int i = 0; i < exp_req.size(); i++) begin
            if (req_log[i] !== exp_req[i]) begin
              errors++; $display("FAIL rand%0d_req%0d got=%h exp=%h", r, i, req_log[i], exp_req[i]);
              break;
            end
          end
        end
        checks++; if (pc_snap !== exp_pc) begin errors++; $display("FAIL rand%0d_pc got=%h exp=%h", r, pc_snap, exp_pc); end
      end
      checks++; if (addr_unstable !== 1'b0) begin errors++; $display("FAIL rand%0d_addr_stable got=%b exp=0", r, addr_unstable); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    test_reset();
    test_mov();
    test_reset();
    test_mvi_waits();
    test_lda();
    test_illegal();
    test_wrap();
    test_reset_in_load();
    test_halt_imm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
